// File: rtl/core_sram_pkg.sv
// Shared types and byte-lane helpers for the core-side SRAM request port.
package core_sram_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  // Misaligned half/word accesses and the reserved size code are errors.
  function automatic logic lane_err(input logic [1:0] size, input logic [1:0] off);
    logic e;
    case (size)
      SZ_BYTE: e = 1'b0;
      SZ_HALF: e = off[0];
      SZ_WORD: e = (off != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] off,
                                               input logic uns, input logic [31:0] q);
    logic [31:0] sh;
    logic [15:0] h;
    logic [31:0] r;
    sh = q >> {off, 3'b000};
    h  = off[1] ? q[31:16] : q[15:0];
    case (size)
      SZ_BYTE: r = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/core_sram_resp_fifo.sv
// In-order response buffer; push is ignored when full and pop when empty.
module core_sram_resp_fifo
  import core_sram_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  resp_t                      push_data,
  input  logic                       pop,
  output resp_t                      pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PONE_C  = PW'(1);
  localparam logic [CW-1:0] CONE_C  = CW'(1);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);

  resp_t           mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            do_push_s;
  logic            do_pop_s;

  assign do_push_s = push & (count_r != FULL_C);
  assign do_pop_s  = pop & (count_r != {CW{1'b0}});
  assign pop_data  = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array, written at the tail pointer.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH need not be a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= (wr_ptr_r == LAST_C) ? {PW{1'b0}} : wr_ptr_r + PONE_C;
      end
      if (do_pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_C) ? {PW{1'b0}} : rd_ptr_r + PONE_C;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CONE_C;
        2'b01:   count_r <= count_r - CONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/core_sram_req_port.sv
// LSU-facing request port for one SRAM port: lane decode on accept, 1-cycle read capture,
// credit-limited in-order response FIFO.
module core_sram_req_port
  import core_sram_pkg::*;
#(
  parameter int ADDRWIDTH  = 14,
  parameter int DATAWIDTH  = 32,
  parameter int RESP_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [ADDRWIDTH+1:0] req_addr_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [DATAWIDTH-1:0] req_wdata_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DATAWIDTH-1:0] resp_rdata_o,
  output logic                 resp_err_o,
  output logic [ADDRWIDTH-1:0] sram_addr_o,
  output logic                 sram_we_o,
  output logic [3:0]           sram_be_o,
  output logic [DATAWIDTH-1:0] sram_d_o,
  input  logic [DATAWIDTH-1:0] sram_q_i
);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic          req_ready_r;
  logic [CW-1:0] outst_r;
  logic [CW-1:0] outst_next_s;
  logic          accept_s;
  logic          err_s;
  logic          pop_s;
  logic [1:0]    off_s;

  logic          cap_valid_r;
  logic          cap_we_r;
  logic          cap_err_r;
  logic [1:0]    cap_size_r;
  logic          cap_unsigned_r;
  logic [1:0]    cap_off_r;

  resp_t         push_data_s;
  resp_t         pop_data_s;
  logic [CW-1:0] fifo_count_s;

  assign off_s       = req_addr_i[1:0];
  assign accept_s    = req_valid_i & req_ready_r;
  assign err_s       = lane_err(req_size_i, off_s);
  assign req_ready_o = req_ready_r;

  assign sram_addr_o = req_addr_i[ADDRWIDTH+1:2];
  assign sram_we_o   = accept_s & req_we_i & ~err_s;
  assign sram_be_o   = sram_we_o ? lane_be(req_size_i, off_s) : 4'h0;
  assign sram_d_o    = lane_replicate(req_size_i, req_wdata_i);

  assign resp_valid_o = (fifo_count_s != {CW{1'b0}});
  assign pop_s        = resp_valid_o & resp_ready_i;
  assign resp_rdata_o = resp_valid_o ? pop_data_s.rdata : 32'h0000_0000;
  assign resp_err_o   = resp_valid_o & pop_data_s.err;

  // Outstanding credits: capture stage plus FIFO entries never exceed RESP_DEPTH.
  always_comb begin
    outst_next_s = outst_r;
    case ({accept_s, pop_s})
      2'b10:   outst_next_s = outst_r + ONE_C;
      2'b01:   outst_next_s = outst_r - ONE_C;
      default: outst_next_s = outst_r;
    endcase
  end

  // Credit counter and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_r     <= {CW{1'b0}};
      req_ready_r <= 1'b0;
    end else begin
      outst_r     <= outst_next_s;
      req_ready_r <= (outst_next_s < DEPTH_C);
    end
  end

  // Capture the attributes needed to shape the response when read data returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid_r    <= 1'b0;
      cap_we_r       <= 1'b0;
      cap_err_r      <= 1'b0;
      cap_size_r     <= 2'd0;
      cap_unsigned_r <= 1'b0;
      cap_off_r      <= 2'd0;
    end else begin
      cap_valid_r <= accept_s;
      if (accept_s) begin
        cap_we_r       <= req_we_i;
        cap_err_r      <= err_s;
        cap_size_r     <= req_size_i;
        cap_unsigned_r <= req_unsigned_i;
        cap_off_r      <= off_s;
      end
    end
  end

  // Response shaping: stores and errors carry zero data.
  always_comb begin
    push_data_s = {32'h0000_0000, 1'b0};
    if (cap_err_r) begin
      push_data_s.err = 1'b1;
    end else if (cap_we_r) begin
      push_data_s.rdata = 32'h0000_0000;
    end else begin
      push_data_s.rdata = lane_extract(cap_size_r, cap_off_r, cap_unsigned_r, sram_q_i);
    end
  end

  core_sram_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cap_valid_r),
    .push_data (push_data_s),
    .pop       (pop_s),
    .pop_data  (pop_data_s),
    .count     (fifo_count_s)
  );

endmodule

// File: tb/tb_core_sram_req_port.sv
// Scoreboard bench for core_sram_req_port with a behavioural 1-cycle SRAM on port A.
module tb_core_sram_req_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [13:0] sram_addr;
  logic        sram_we;
  logic [3:0]  sram_be;
  logic [31:0] sram_d;
  logic [31:0] sram_q;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    bit          chk_lat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] mem [0:16383];

  core_sram_req_port #(.ADDRWIDTH(14), .DATAWIDTH(32), .RESP_DEPTH(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_addr_i     (req_addr),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err),
    .sram_addr_o    (sram_addr),
    .sram_we_o      (sram_we),
    .sram_be_o      (sram_be),
    .sram_d_o       (sram_d),
    .sram_q_i       (sram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM port A: byte-enabled write, registered read.
  always @(posedge clk) begin
    if (sram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_be[i]) mem[sram_addr][8*i +: 8] <= sram_d[8*i +: 8];
      end
    end
    sram_q <= mem[sram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every response handshake pops and checks the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_resp: got rdata 0x%08h err %0b with nothing outstanding",
                 resp_rdata, resp_err);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, mon_e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
        if (mon_e.chk_lat) chk("latency", 32'(cyc - mon_e.acc), 32'd2);
      end
    end
  end

  // Call just after a rising edge; returns just after the accepting edge, valid left high.
  task automatic send(input logic we, input logic [15:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata, input logic [3:0] exp_be,
                      input logic [31:0] exp_d, input logic [31:0] exp_rdata,
                      input logic exp_err, input bit chk_lat);
    exp_t e;
    int   t;
    bit   got;
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    t   = 0;
    got = 1'b0;
    while (!got && t < 50) begin
      @(negedge clk);
      if (req_ready === 1'b1) got = 1'b1;
      else begin
        @(posedge clk); #1;
        t++;
      end
    end
    if (!got) begin
      chk("req_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end else begin
      chk("sram_addr", {18'd0, sram_addr}, {18'd0, addr[15:2]});
      chk("sram_we", {31'd0, sram_we}, {31'd0, (exp_be != 4'h0)});
      chk("sram_be", {28'd0, sram_be}, {28'd0, exp_be});
      if (exp_be != 4'h0) chk("sram_d", sram_d, exp_d);
      e.rdata   = exp_rdata;
      e.err     = exp_err;
      e.acc     = cyc;
      e.chk_lat = chk_lat;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0;
    req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0; resp_ready = 1'b0;

    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_sram_we", {31'd0, sram_we}, 32'd0);
    chk("rst_sram_be", {28'd0, sram_be}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", {31'd0, req_ready}, 32'd1);
    resp_ready = 1'b1;

    // we, addr, size, uns, wdata, be, d, rdata, err, lat
    send(1'b1, 16'h0010, 2'd2, 1'b0, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    send(1'b0, 16'h0010, 2'd2, 1'b0, 32'h0,        4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    send(1'b1, 16'h0013, 2'd0, 1'b0, 32'h000000AA, 4'h8, 32'hAAAAAAAA, 32'h0, 1'b0, 1'b0);
    send(1'b0, 16'h0013, 2'd0, 1'b0, 32'h0,        4'h0, 32'h0, 32'hFFFFFFAA, 1'b0, 1'b0);
    send(1'b0, 16'h0013, 2'd0, 1'b1, 32'h0,        4'h0, 32'h0, 32'h000000AA, 1'b0, 1'b0);
    send(1'b0, 16'h0010, 2'd2, 1'b0, 32'h0,        4'h0, 32'h0, 32'hAAADBEEF, 1'b0, 1'b0);
    send(1'b1, 16'h0010, 2'd2, 1'b0, 32'h80011234, 4'hF, 32'h80011234, 32'h0, 1'b0, 1'b0);
    send(1'b0, 16'h0012, 2'd1, 1'b0, 32'h0,        4'h0, 32'h0, 32'hFFFF8001, 1'b0, 1'b0);
    send(1'b0, 16'h0010, 2'd1, 1'b1, 32'h0,        4'h0, 32'h0, 32'h00001234, 1'b0, 1'b0);
    send(1'b1, 16'h0011, 2'd2, 1'b0, 32'h55555555, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    send(1'b0, 16'h0010, 2'd2, 1'b0, 32'h0,        4'h0, 32'h0, 32'h80011234, 1'b0, 1'b0);
    send(1'b0, 16'h0010, 2'd3, 1'b0, 32'h0,        4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    send(1'b0, 16'h0011, 2'd1, 1'b0, 32'h0,        4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    send(1'b1, 16'h0014, 2'd2, 1'b0, 32'h11223344, 4'hF, 32'h11223344, 32'h0, 1'b0, 1'b0);
    send(1'b1, 16'h0016, 2'd1, 1'b0, 32'h1234ABCD, 4'hC, 32'hABCDABCD, 32'h0, 1'b0, 1'b0);
    idle();
    drain();

    // Backpressure: three credits, then the fourth request must wait for a pop.
    resp_ready = 1'b0;
    send(1'b0, 16'h0010, 2'd2, 1'b0, 32'h0, 4'h0, 32'h0, 32'h80011234, 1'b0, 1'b0);
    send(1'b0, 16'h0014, 2'd2, 1'b0, 32'h0, 4'h0, 32'h0, 32'hABCD3344, 1'b0, 1'b0);
    send(1'b0, 16'h0011, 2'd0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h00000012, 1'b0, 1'b0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0016; req_size = 2'd1; req_unsigned = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    send(1'b0, 16'h0016, 2'd1, 1'b0, 32'h0, 4'h0, 32'h0, 32'hFFFFABCD, 1'b0, 1'b0);
    idle();
    drain();

    // Reset with two loads outstanding.
    resp_ready = 1'b0;
    send(1'b0, 16'h0010, 2'd2, 1'b0, 32'h0, 4'h0, 32'h0, 32'h80011234, 1'b0, 1'b0);
    send(1'b0, 16'h0014, 2'd2, 1'b0, 32'h0, 4'h0, 32'h0, 32'hABCD3344, 1'b0, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    chk("rst_hold_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel_req_ready", {31'd0, req_ready}, 32'd1);
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_resp", {31'd0, resp_valid}, 32'd0);
    end

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/core_sram_req_port.md
Name: core_sram_req_port

Overview:
- Initiator-side controller for one port of the team's dual-port SRAM macro.
- Accepts byte-addressed load/store requests from the core LSU over a valid/ready handshake.
- Drives word address, write enable, byte enables and lane-replicated write data to the SRAM; captures the 1-cycle-latency read data; returns in-order, sign/zero-extended responses over a valid/ready handshake.

Parameters:
- ADDRWIDTH, 14: SRAM word-address width; the request address is ADDRWIDTH+2 bits (byte address).
- DATAWIDTH, 32: SRAM word width; fixed at 32, because size decoding assumes 4 byte lanes.
- RESP_DEPTH, 3: maximum outstanding requests and response FIFO depth; 3 gives full throughput.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready (registered)
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  ADDRWIDTH+2  byte address
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned_i  in  1  zero-extend load data
- req_wdata_i  in  32  store data, right-aligned
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response ready
- resp_rdata_o  out  32  extended load data; 0 for stores and errors
- resp_err_o  out  1  misaligned or illegal-size request
- sram_addr_o  out  ADDRWIDTH  word address, req_addr_i[ADDRWIDTH+1:2]
- sram_we_o  out  1  SRAM write enable
- sram_be_o  out  4  SRAM byte enables
- sram_d_o  out  32  SRAM write data
- sram_q_i  in  32  SRAM read data, valid one cycle after the address

Behaviour:
- Reset values:
  - req_ready_o=0; it rises in the first cycle after reset release.
  - resp_valid_o=0; outstanding count 0; capture stage invalid; FIFO empty.
  - sram_we_o=0, sram_be_o=0.
- Request handshake:
  - A request is accepted when req_valid_i && req_ready_o.
  - req_ready_o is registered: next value = (outstanding_next < RESP_DEPTH).
- Outstanding counter:
  - +1 on accept, -1 on response handshake.
  - Both in the same cycle: counter unchanged.
- SRAM drive (combinational, only in the accept cycle):
  - sram_addr_o follows req_addr_i in every cycle.
  - sram_we_o = accept && req_we_i && !err.
  - sram_be_o = byte: 1<<off; half: 3<<off; word: 4'hF; 0 when no write.
  - off = req_addr_i[1:0].
- Write data replication: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Error condition: err = size 3, or half with off[0]=1, or word with off!=0.
  - Errored requests are still accepted and consume a slot.
  - They never write the SRAM.
  - They respond with resp_err_o=1 and rdata 0.
- Capture stage: one register holding {valid, we, err, size, unsigned, off} for the accepted request.
  - In cycle N+1, sram_q_i is sliced and extended, then pushed into the FIFO.
  - Load byte: q[8*off+:8]; half: q[16*off[1]+:16]; word: q.
  - Sign-extend unless req_unsigned_i was set.
- Latency: a request accepted in cycle N presents resp_valid_o in cycle N+2 at the earliest.
- Throughput: back-to-back acceptance with resp_ready_i held high gives one response per cycle.
- Ordering: responses are strictly in request order; the FIFO never overflows, because the credit scheme guarantees a free slot.
- Backpressure: with resp_ready_i low, at most RESP_DEPTH requests are accepted, then req_ready_o drops.
  - No SRAM access occurs while req_ready_o is low.
- Reset mid-operation:
  - All in-flight and buffered responses are discarded; resp_valid_o drops immediately.
  - No stale response appears after reset release.
- Port B of the SRAM is not driven by this block.

Decomposition:
- Shared package core_sram_pkg holds:
  - size_e enum: SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2.
  - resp_t struct: {rdata[31:0], err}.
  - Lane-decode helper functions for be/replicate/extract.
- Sub-module core_sram_resp_fifo: synchronous FIFO of resp_t, DEPTH=RESP_DEPTH, push/pop/count, asynchronous active-low reset.

Test Plan:
- Word store at addr 0x10, data 0xDEADBEEF:
  - sram_addr_o=4, be=4'hF, we=1, d=0xDEADBEEF; response err=0, rdata=0.
  - Load from 0x10 -> rdata 0xDEADBEEF exactly 2 cycles after accept.
- Byte store at 0x13, data 0x000000AA -> be=4'h8, d=0xAAAAAAAA.
  - Signed byte load at 0x13 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- Word at 0x10 preset to 0x80011234:
  - Signed half load at 0x12 -> 0xFFFF8001.
  - Unsigned half load at 0x10 -> 0x00001234.
- Misaligned word store at 0x11 -> sram_we_o stays 0, memory unchanged, response err=1, rdata=0.
- Backpressure: resp_ready_i=0, 4 back-to-back loads -> 3 accepted, req_ready_o=0, 4th not issued.
  - Raise resp_ready_i -> 4th issued after the first pop; 4 responses in order.
- Reset asserted with 2 loads outstanding -> resp_valid_o=0 at once, req_ready_o=0 during reset, 1 in the first cycle after release, no responses emitted afterward.
